// File: rtl/event_pkg.sv
// Shared types and constants for the event sampler: FSM states, LFSR taps, statistics width.
package event_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StDecide,
        StOutput,
        StHold
    } state_e;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LfsrTaps = 32'h8020_0003;
    localparam int unsigned CntW     = 16;

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (v == {CntW{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/event_lfsr.sv
// Free-running 32-bit maximal-length Galois LFSR; a zero seed is forced to 1.
module event_lfsr import event_pkg::*; #(
    parameter logic [31:0] Seed = 32'h1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] state_o
);

    localparam logic [31:0] SeedEff = (Seed == 32'h0) ? 32'h1 : Seed;

    logic [31:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LfsrTaps;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= SeedEff;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/event_sampler.sv
// Rejection sampler: draws random (q, t, x, y), accepts when LUT p(t) > q and t is in window,
// then emits four derived coordinates over a valid/ready handshake.
module event_sampler import event_pkg::*; #(
    parameter int unsigned COORD_W   = 10,
    parameter int unsigned AXIS_W    = 6,
    parameter logic [31:0] LFSR_SEED = 32'h1,
    parameter int unsigned LUT_LAT   = 1,
    parameter int unsigned T_MIN     = 32,
    parameter int unsigned T_MAX     = 734,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned HOLDOFF   = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    output logic               busy_o,
    output logic [COORD_W-1:0] lut_addr_o,
    input  logic [COORD_W-1:0] lut_data_i,
    output logic               evt_valid_o,
    input  logic               evt_ready_i,
    output logic [COORD_W-1:0] x1_o,
    output logic [COORD_W-1:0] x2_o,
    output logic [COORD_W-1:0] y1_o,
    output logic [COORD_W-1:0] y2_o,
    output logic               reject_o,
    output logic [CntW-1:0]    acc_cnt_o,
    output logic [CntW-1:0]    rej_cnt_o,
    output logic [CntW-1:0]    drop_cnt_o
);

    localparam int unsigned RandW  = 2 * COORD_W + 2 * AXIS_W;
    localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned HoldW  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [RetryW-1:0]  RetryLoad = RetryW'(MAX_RETRY);
    localparam logic [HoldW-1:0]   HoldLoad  = HoldW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [1:0]         WaitLoad  = 2'(LUT_LAT - 1);
    localparam logic [COORD_W-1:0] AxisOfs   = COORD_W'(1 << (AXIS_W - 1));

    if (RandW > 32) begin : g_rand_w_check
        $error("event_sampler: 2*COORD_W + 2*AXIS_W must not exceed 32");
    end
    if (LUT_LAT < 1 || LUT_LAT > 4) begin : g_lut_lat_check
        $error("event_sampler: LUT_LAT must be within 1..4");
    end

    state_e               state_q, state_d;
    logic [RandW-1:0]     draw_q, draw_d;
    logic [1:0]           wait_q, wait_d;
    logic [RetryW-1:0]    retry_q, retry_d;
    logic [HoldW-1:0]     hold_q, hold_d;
    logic [COORD_W-1:0]   x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
    logic [CntW-1:0]      acc_q, acc_d, rej_q, rej_d, drop_cnt_q, drop_cnt_d;

    logic [31:0]          lfsr_word;
    logic [COORD_W-1:0]   draw_qv, draw_t, x_ext, y_ext;
    logic                 accept;
    logic                 start_take;

    event_lfsr #(
        .Seed(LFSR_SEED)
    ) u_lfsr (
        .clk_i  (clk),
        .rst_i  (reset),
        .state_o(lfsr_word)
    );

    assign draw_qv = draw_q[COORD_W-1:0];
    assign draw_t  = draw_q[2*COORD_W-1:COORD_W];
    assign x_ext   = COORD_W'(draw_q[2*COORD_W +: AXIS_W]);
    assign y_ext   = COORD_W'(draw_q[2*COORD_W+AXIS_W +: AXIS_W]);

    assign accept = (lut_data_i > draw_qv) &&
                    (32'(draw_t) >= T_MIN) && (32'(draw_t) <= T_MAX);

    always_comb begin
        state_d    = state_q;
        draw_d     = draw_q;
        wait_d     = wait_q;
        retry_d    = retry_q;
        hold_d     = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        acc_d      = acc_q;
        rej_d      = rej_q;
        drop_cnt_d = drop_cnt_q;
        reject_o   = 1'b0;
        start_take = 1'b0;

        unique case (state_q)
            StIdle: start_take = start_i;
            StWait: begin
                if (wait_q == '0) begin
                    state_d = StDecide;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            StDecide: begin
                if (accept) begin
                    x1_d    = draw_t + AxisOfs - x_ext;
                    x2_d    = draw_t - AxisOfs + x_ext;
                    y1_d    = draw_t + AxisOfs - y_ext;
                    y2_d    = draw_t - AxisOfs + y_ext;
                    state_d = StOutput;
                end else if (retry_q != '0) begin
                    retry_d = retry_q - 1'b1;
                    draw_d  = lfsr_word[RandW-1:0];
                    wait_d  = WaitLoad;
                    state_d = StWait;
                end else begin
                    reject_o = 1'b1;
                    rej_d    = sat_inc(rej_q);
                    state_d  = StHold;
                end
            end
            StOutput: begin
                if (evt_ready_i) begin
                    acc_d   = sat_inc(acc_q);
                    state_d = StHold;
                end
            end
            StHold: begin
                // An expired holdoff accepts a start in the same cycle it returns to idle
                if (hold_q == '0) begin
                    state_d    = StIdle;
                    start_take = start_i;
                end
            end
            default: state_d = StIdle;
        endcase

        if (start_take) begin
            draw_d  = lfsr_word[RandW-1:0];
            wait_d  = WaitLoad;
            retry_d = RetryLoad;
            hold_d  = HoldLoad;
            state_d = StWait;
        end else if (start_i) begin
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            draw_q     <= '0;
            wait_q     <= '0;
            retry_q    <= '0;
            hold_q     <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            y1_q       <= '0;
            y2_q       <= '0;
            acc_q      <= '0;
            rej_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            draw_q     <= draw_d;
            wait_q     <= wait_d;
            retry_q    <= retry_d;
            hold_q     <= hold_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign busy_o      = (state_q != StIdle);
    assign evt_valid_o = (state_q == StOutput);
    assign lut_addr_o  = draw_t;
    assign x1_o        = x1_q;
    assign x2_o        = x2_q;
    assign y1_o        = y1_q;
    assign y2_o        = y2_q;
    assign acc_cnt_o   = acc_q;
    assign rej_cnt_o   = rej_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_event_sampler.sv
// Scoreboard bench for event_sampler: predicts each start's outcome and timing from an LFSR model.
module tb_event_sampler;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned AXIS_W    = 6;
    localparam int unsigned LUT_LAT   = 1;
    localparam int unsigned T_MIN     = 32;
    localparam int unsigned T_MAX     = 734;
    localparam int unsigned MAX_RETRY = 3;
    localparam int unsigned HOLDOFF   = 100;
    localparam logic [31:0] SEED      = 32'hACE1_2468;
    localparam logic [31:0] POLY      = 32'h8020_0003;

    typedef struct {
        bit          is_evt;
        int unsigned cyc;
        logic [9:0]  x1, x2, y1, y2;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic       busy_o;
    logic [9:0] lut_addr_o;
    logic [9:0] lut_data_i;
    logic       evt_valid_o;
    logic       evt_ready_i;
    logic [9:0] x1_o, x2_o, y1_o, y2_o;
    logic       reject_o;
    logic [15:0] acc_cnt_o, rej_cnt_o, drop_cnt_o;

    event_sampler #(
        .COORD_W  (COORD_W),
        .AXIS_W   (AXIS_W),
        .LFSR_SEED(SEED),
        .LUT_LAT  (LUT_LAT),
        .T_MIN    (T_MIN),
        .T_MAX    (T_MAX),
        .MAX_RETRY(MAX_RETRY),
        .HOLDOFF  (HOLDOFF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .busy_o     (busy_o),
        .lut_addr_o (lut_addr_o),
        .lut_data_i (lut_data_i),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .x1_o       (x1_o),
        .x2_o       (x2_o),
        .y1_o       (y1_o),
        .y2_o       (y2_o),
        .reject_o   (reject_o),
        .acc_cnt_o  (acc_cnt_o),
        .rej_cnt_o  (rej_cnt_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc;
    logic [31:0] m_lfsr;
    int unsigned lut_mode = 0;
    bit          rand_rdy = 0;
    bit          evt_seen = 0;
    exp_t        sb[$];
    int unsigned exp_acc = 0, exp_rej = 0, exp_drop = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ POLY;
        return s;
    endfunction

    function automatic logic [9:0] lut_fn(input logic [9:0] t, input int unsigned mode);
        case (mode)
            0:       return 10'd1023;
            1:       return 10'd0;
            default: return {t[4:0], t[9:5]} ^ 10'h155;
        endcase
    endfunction

    // Reference clock-count and LFSR, both restarted by reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            m_lfsr <= SEED;
        end else begin
            cyc    <= cyc + 1;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    always @(posedge clk) lut_data_i <= lut_fn(lut_addr_o, lut_mode);

    task automatic push_expect();
        logic [31:0] w;
        logic [9:0]  q, t, x, y;
        exp_t        e;
        bit          done;
        w = m_lfsr;
        done = 0;
        e.is_evt = 0; e.cyc = 0; e.x1 = 0; e.x2 = 0; e.y1 = 0; e.y2 = 0;
        for (int r = 0; r <= int'(MAX_RETRY) && !done; r++) begin
            q = w[9:0];
            t = w[19:10];
            x = 10'(w[25:20]);
            y = 10'(w[31:26]);
            if (lut_fn(t, lut_mode) > q && 32'(t) >= T_MIN && 32'(t) <= T_MAX) begin
                e.is_evt = 1;
                e.cyc = cyc + LUT_LAT + 2 + r * (LUT_LAT + 1);
                e.x1 = t + 10'd32 - x;
                e.x2 = t - 10'd32 + x;
                e.y1 = t + 10'd32 - y;
                e.y2 = t - 10'd32 + y;
                exp_acc++;
                done = 1;
            end else if (r == int'(MAX_RETRY)) begin
                e.cyc = cyc + LUT_LAT + 1 + r * (LUT_LAT + 1);
                exp_rej++;
            end
            for (int k = 0; k < int'(LUT_LAT) + 1; k++) w = lfsr_step(w);
        end
        sb.push_back(e);
    endtask

    // Called right after a falling edge; returns one falling edge later
    task automatic pulse_start(input bit accepted);
        if (accepted) push_expect();
        else exp_drop++;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned bound);
        int unsigned n;
        n = 0;
        while (busy_o && n < bound) begin
            @(negedge clk);
            if (rand_rdy) evt_ready_i = ($urandom_range(0, 2) != 0);
            n++;
        end
        check_val("idle_timeout", busy_o, 1'b0);
    endtask

    task automatic check_counts(input string tag);
        check_val({tag, "_acc"}, acc_cnt_o, exp_acc);
        check_val({tag, "_rej"}, rej_cnt_o, exp_rej);
        check_val({tag, "_drop"}, drop_cnt_o, exp_drop);
    endtask

    always @(negedge clk) begin
        #1;
        if (!reset && (evt_valid_o || reject_o)) begin
            check_val("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                if (evt_valid_o) begin
                    if (!evt_seen) begin
                        check_val("evt_kind", {evt_valid_o, reject_o}, sb[0].is_evt ? 2'b10 : 2'b01);
                        check_val("evt_cycle", cyc, sb[0].cyc);
                        evt_seen = 1;
                    end
                    check_val("x1", x1_o, sb[0].x1);
                    check_val("x2", x2_o, sb[0].x2);
                    check_val("y1", y1_o, sb[0].y1);
                    check_val("y2", y2_o, sb[0].y2);
                    if (evt_ready_i) begin
                        void'(sb.pop_front());
                        evt_seen = 0;
                    end
                end else begin
                    check_val("rej_kind", {evt_valid_o, reject_o}, sb[0].is_evt ? 2'b10 : 2'b01);
                    check_val("rej_cycle", cyc, sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        logic [9:0]  t_exp[4];
        bit          got;
        int unsigned n, acc_before;

        reset = 1'b1;
        start_i = 1'b0;
        evt_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy_o, 1'b0);
        check_val("rst_valid", evt_valid_o, 1'b0);
        check_val("rst_reject", reject_o, 1'b0);
        check_val("rst_coords", {x1_o, x2_o, y1_o, y2_o}, 40'h0);
        check_val("rst_addr", lut_addr_o, 10'h0);
        check_counts("rst");
        reset = 1'b0;
        @(negedge clk);

        // Always-high p: accept depends only on q and the time window
        lut_mode = 0;
        for (int i = 0; i < 5; i++) begin
            pulse_start(1);
            wait_idle(300);
        end
        check_counts("p_max");

        // p = 0: every draw is rejected; four draws on consecutive lut_addr updates
        lut_mode = 1;
        w = m_lfsr;
        for (int r = 0; r < 4; r++) begin
            t_exp[r] = w[19:10];
            for (int k = 0; k < int'(LUT_LAT) + 1; k++) w = lfsr_step(w);
        end
        pulse_start(1);
        for (int r = 0; r < 4; r++) begin
            check_val("draw_addr", lut_addr_o, t_exp[r]);
            if (r < 3) repeat (LUT_LAT + 1) @(negedge clk);
        end
        repeat (HOLDOFF - 7) @(negedge clk);
        check_val("hold_busy_last", busy_o, 1'b1);
        @(negedge clk);
        check_val("hold_busy_done", busy_o, 1'b0);
        check_counts("p_zero");

        // Holdoff: starts 50 apart, the middle one dropped, the third drawn at +100
        lut_mode = 0;
        pulse_start(1);
        repeat (49) @(negedge clk);
        pulse_start(0);
        repeat (49) @(negedge clk);
        pulse_start(1);
        wait_idle(300);
        check_counts("holdoff");

        // Backpressure: event must stay put while ready is low
        got = 0;
        for (int a = 0; a < 6 && !got; a++) begin
            evt_ready_i = 1'b0;
            pulse_start(1);
            n = 0;
            while (!evt_valid_o && busy_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (evt_valid_o) begin
                got = 1;
                acc_before = acc_cnt_o;
                repeat (10) begin
                    check_val("bp_valid", evt_valid_o, 1'b1);
                    @(negedge clk);
                end
                evt_ready_i = 1'b1;
                @(negedge clk);
                check_val("bp_valid_drop", evt_valid_o, 1'b0);
                check_val("bp_acc_step", acc_cnt_o, acc_before + 1);
            end
            evt_ready_i = 1'b1;
            wait_idle(300);
        end
        check_val("bp_got_event", got, 1'b1);
        check_counts("bp");

        // Mixed p(t) with random ready stalls
        lut_mode = 2;
        rand_rdy = 1;
        for (int i = 0; i < 8; i++) begin
            pulse_start(1);
            wait_idle(400);
        end
        rand_rdy = 0;
        evt_ready_i = 1'b1;
        check_counts("mixed");

        // Reset while waiting on the LUT aborts cleanly
        lut_mode = 0;
        pulse_start(1);
        reset = 1'b1;
        sb.delete();
        evt_seen = 0;
        exp_acc = 0; exp_rej = 0; exp_drop = 0;
        @(posedge clk);
        #1;
        check_val("wrst_busy", busy_o, 1'b0);
        check_val("wrst_valid", evt_valid_o, 1'b0);
        check_val("wrst_reject", reject_o, 1'b0);
        check_val("wrst_coords", {x1_o, x2_o, y1_o, y2_o}, 40'h0);
        check_counts("wrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start(1);
        wait_idle(300);
        check_counts("post_rst");

        // Drop counter saturation
        force dut.drop_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.drop_cnt_q;
        @(negedge clk);
        pulse_start(1);
        pulse_start(0);
        check_val("drop_fffe_plus1", drop_cnt_o, 16'hFFFF);
        pulse_start(0);
        pulse_start(0);
        check_val("drop_saturate", drop_cnt_o, 16'hFFFF);
        wait_idle(300);
        check_val("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
